mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Multiply/divide unit and HI/LO sequencer for the 5-stage MIPS pipeline; sits in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from E and runs multi-cycle operations with a down-counter.
- Commits results to the architectural HI/LO registers.
- Exports start and busy to the D-stage stall logic, which holds every HI/LO instruction in D while (busy | start).

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (legal 1..15).
- DIV_CYCLES, 10, busy cycles for div/divu (legal 1..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- valid  input  1  E-stage instruction valid (0 = bubble).
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9..15 none.
- rs_val  input  32  forwarded rs operand.
- rt_val  input  32  forwarded rt operand.
- start  output  1  combinational: valid & op in 1..4 & !busy.
- busy  output  1  registered; operation in flight.
- rd_data  output  32  combinational: hi when op=5, lo when op=6, else 0.
- hi  output  32  architectural HI.
- lo  output  32  architectural LO.

Behaviour:
- Reset: asynchronous on reset_n=0. Clears busy, counter, hi, lo, and the pending result registers to 0. Reset mid-operation aborts the operation; no commit follows.
- Idle/start: state IDLE (busy=0) or RUN (busy=1). At an edge with start=1:
  - Compute the full result into pend_hi/pend_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy<=1.
- RUN: counter decrements each edge. At the edge where counter==1:
  - hi<=pend_hi, lo<=pend_lo, busy<=0, counter<=0.
- Latency: busy is high for exactly N cycles after the start edge. New HI/LO values are visible on hi/lo in the cycle busy first reads 0.
- mult: signed 32x32 to 64; hi=[63:32], lo=[31:0].
- multu: unsigned 32x32 to 64; hi=[63:32], lo=[31:0].
- div (signed): lo = quotient truncated toward zero; hi = remainder, sign follows the dividend (rs).
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- divu: unsigned quotient to lo, remainder to hi.
- Divide by zero (rt_val=0, div or divu): counter and busy sequence normally; hi/lo keep their prior values at completion.
- mthi/mtlo: when valid & !busy, hi<=rs_val (op 7) or lo<=rs_val (op 8) at the edge, single cycle.
- mfhi/mflo: rd_data is combinational from the current hi/lo.
- busy=1 with valid and an op in 1..8: ignored. No start, no write, no state change. The stall unit makes this unreachable; the block still must not corrupt state.
- valid=0: no action regardless of op.
- start is never asserted while busy=1, so start and commit never coincide. mthi/mtlo are blocked during busy, so a commit and a direct write cannot collide.
- No other state. The pipeline has no exceptions, so cancel/flush inputs are not provided.

Test Plan:
- Reset:
  - Apply reset_n=0 asynchronously mid-cycle, then release. Required: hi=lo=0, busy=0, start=0.
  - Issue mult 3 x 4, assert reset_n=0 at cycle 2 of busy. Required: busy drops immediately, hi=lo=0, no commit afterwards.
- mult signed: rs=0xFFFFFFFE (-2), rt=3, valid=1, op=1 for one cycle.
  - Required: start=1 that cycle, busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu: rs=rt=0xFFFFFFFF. Required: after 5 busy cycles hi=0xFFFFFFFE, lo=0x00000001.
- div signed: rs=-7 (0xFFFFFFF9), rt=2.
  - Required: busy for 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Repeat with rs=0x80000000, rt=0xFFFFFFFF. Required: lo=0x80000000, hi=0.
- Divide by zero and blocked ops:
  - Preload hi=0x11111111 via mthi. Issue divu rs=5, rt=0. Required: busy for 10 cycles, hi stays 0x11111111.
  - Issue mtlo rs=0x1234 while busy. Required: lo unchanged, start=0.
- Back-to-back and reads:
  - mult completes, then mflo (op=6) in the first cycle busy=0. Required: rd_data equals the new lo.
  - A second mult in the same cycle busy falls. Required: start=1 and a new 5-cycle busy window.

Source files
------------

// File: rtl/mdu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | mdu_ctrl : E-stage multiply/divide unit and HI/LO register sequencer     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid,
  input  logic [3:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        start,
  output logic        busy,
  output logic [31:0] rd_data,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [3:0] MUL_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic        is_mdu;
  logic        is_div;
  logic        signed_op;
  logic [63:0] mul_a;
  logic [63:0] mul_b;
  logic [63:0] product;
  logic        neg_a;
  logic        neg_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_den;
  logic [31:0] quot_mag;
  logic [31:0] rem_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy      = (state == RUN);
  assign is_mdu    = (op >= 4'd1) && (op <= 4'd4);
  assign is_div    = (op == 4'd3) || (op == 4'd4);
  assign signed_op = (op == 4'd1) || (op == 4'd3);
  assign start     = valid && is_mdu && !busy;

  // One 64-bit multiplier serves both flavours: low 64 bits of the
  // sign/zero-extended product are the exact 32x32 result.
  assign mul_a   = {{32{signed_op & rs_val[31]}}, rs_val};
  assign mul_b   = {{32{signed_op & rt_val[31]}}, rt_val};
  assign product = mul_a * mul_b;

  // Signed divide via magnitudes keeps 0x80000000 / -1 well defined.
  assign neg_a    = signed_op & rs_val[31];
  assign neg_b    = signed_op & rt_val[31];
  assign mag_a    = neg_a ? -rs_val : rs_val;
  assign mag_b    = neg_b ? -rt_val : rt_val;
  assign div_den  = (rt_val == 32'd0) ? 32'd1 : mag_b;
  assign quot_mag = mag_a / div_den;
  assign rem_mag  = mag_a % div_den;
  assign quot     = (neg_a ^ neg_b) ? -quot_mag : quot_mag;
  assign rem      = neg_a ? -rem_mag : rem_mag;

  always_comb begin
    res_hi = product[63:32];
    res_lo = product[31:0];
    if (is_div) begin
      if (rt_val == 32'd0) begin
        res_hi = hi;
        res_lo = lo;
      end else begin
        res_hi = rem;
        res_lo = quot;
      end
    end
  end

  always_comb begin
    rd_data = 32'd0;
    if (op == 4'd5) rd_data = hi;
    else if (op == 4'd6) rd_data = lo;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= 4'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            count   <= is_div ? DIV_N : MUL_N;
            state   <= RUN;
          end else if (valid && op == 4'd7) begin
            hi <= rs_val;
          end else if (valid && op == 4'd8) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          if (count == 4'd1) begin
            hi    <= pend_hi;
            lo    <= pend_lo;
            count <= 4'd0;
            state <= IDLE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mdu_ctrl : randomized self-checking bench for mdu_ctrl                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid = 1'b0;
  logic [3:0]  op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        start;
  logic        busy;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int          total = 0;
  int          bad = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .valid(valid), .op(op),
    .rs_val(rs_val), .rt_val(rt_val), .start(start), .busy(busy),
    .rd_data(rd_data), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic int latency(input logic [3:0] o);
    return (o == 4'd3 || o == 4'd4) ? 10 : 5;
  endfunction

  // Reference: plain 64-bit arithmetic on the architectural meaning of each op.
  task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin pu = ua * ub; m_hi = pu[63:32]; m_lo = pu[31:0]; end
      4'd3: if (b != 0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 0) begin m_lo = a / b; m_hi = a % b; end
      default: ;
    endcase
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input string name);
    int n;
    valid = 1'b1; op = o; rs_val = a; rt_val = b;
    #1;
    total++;
    if (start !== 1'b1) begin bad++; $display("FAIL %s start: got %b want 1", name, start); end
    model_op(o, a, b);
    step;
    valid = 1'b0; op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin n++; step; end
    total++;
    if (n !== latency(o)) begin bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, n, latency(o)); end
    total++;
    if (hi !== m_hi) begin bad++; $display("FAIL %s hi: got %h want %h", name, hi, m_hi); end
    total++;
    if (lo !== m_lo) begin bad++; $display("FAIL %s lo: got %h want %h", name, lo, m_lo); end
  endtask

  task automatic do_mt(input logic [3:0] o, input logic [31:0] v);
    valid = 1'b1; op = o; rs_val = v;
    step;
    valid = 1'b0; op = 4'd0;
    if (o == 4'd7) m_hi = v; else m_lo = v;
    total++;
    if (hi !== m_hi || lo !== m_lo) begin
      bad++; $display("FAIL mt%0d hi/lo: got %h/%h want %h/%h", o, hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) step;
    @(negedge clk) reset_n = 1'b1;
    step;
    do_mt(4'd7, 32'hDEADBEEF);
    do_mt(4'd8, 32'hCAFEF00D);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    total++; if (hi !== 32'd0) begin bad++; $display("FAIL reset hi: got %h want 0", hi); end
    total++; if (lo !== 32'd0) begin bad++; $display("FAIL reset lo: got %h want 0", lo); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL reset start: got %b want 0", start); end
    @(negedge clk) reset_n = 1'b1;
    step;
  endtask

  task automatic test_reset_mid_op;
    valid = 1'b1; op = 4'd1; rs_val = 32'd3; rt_val = 32'd4;
    step;
    valid = 1'b0; op = 4'd0;
    step;
    #2 reset_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL abort hi/lo: got %h/%h want 0/0", hi, lo);
    end
    @(negedge clk) reset_n = 1'b1;
    repeat (8) step;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort later busy: got %b want 0", busy); end
    total++; if (hi !== 32'd0 || lo !== 32'd0) begin
      bad++; $display("FAIL abort no_commit: got %h/%h want 0/0", hi, lo);
    end
  endtask

  task automatic test_mult;
    run_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult_neg");
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
      bad++; $display("FAIL mult_const: got %h/%h want ffffffff/fffffffa", hi, lo);
    end
    run_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");
    total++; if (hi !== 32'hFFFFFFFE || lo !== 32'h00000001) begin
      bad++; $display("FAIL multu_const: got %h/%h want fffffffe/00000001", hi, lo);
    end
  endtask

  task automatic test_div;
    run_op(4'd3, 32'hFFFFFFF9, 32'd2, "div_neg");
    total++; if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFD) begin
      bad++; $display("FAIL div_const: got %h/%h want ffffffff/fffffffd", hi, lo);
    end
    run_op(4'd3, 32'h80000000, 32'hFFFFFFFF, "div_ovf");
    total++; if (hi !== 32'd0 || lo !== 32'h80000000) begin
      bad++; $display("FAIL div_ovf_const: got %h/%h want 00000000/80000000", hi, lo);
    end
    run_op(4'd4, 32'hFFFFFFF9, 32'd2, "divu");
  endtask

  task automatic test_div_zero_blocked;
    int n;
    do_mt(4'd7, 32'h11111111);
    do_mt(4'd8, 32'h22222222);
    valid = 1'b1; op = 4'd4; rs_val = 32'd5; rt_val = 32'd0;
    #1;
    total++; if (start !== 1'b1) begin bad++; $display("FAIL divz start: got %b want 1", start); end
    step;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == 3) begin
        valid = 1'b1; op = 4'd8; rs_val = 32'h1234;
        #1;
        total++; if (start !== 1'b0) begin bad++; $display("FAIL blocked_mtlo start: got %b want 0", start); end
      end else if (n == 5) begin
        valid = 1'b1; op = 4'd1; rs_val = 32'd7; rt_val = 32'd9;
        #1;
        total++; if (start !== 1'b0) begin bad++; $display("FAIL blocked_mult start: got %b want 0", start); end
      end else begin
        valid = 1'b0; op = 4'd0;
      end
      step;
    end
    valid = 1'b0; op = 4'd0;
    total++; if (n !== 10) begin bad++; $display("FAIL divz busy_cycles: got %0d want 10", n); end
    total++; if (hi !== 32'h11111111) begin bad++; $display("FAIL divz hi: got %h want 11111111", hi); end
    total++; if (lo !== 32'h22222222) begin bad++; $display("FAIL blocked lo: got %h want 22222222", lo); end
  endtask

  task automatic test_back_to_back;
    run_op(4'd1, $urandom, $urandom, "b2b_first");
    valid = 1'b1; op = 4'd6;
    #1;
    total++; if (rd_data !== m_lo) begin bad++; $display("FAIL mflo_after: got %h want %h", rd_data, m_lo); end
    op = 4'd5;
    #1;
    total++; if (rd_data !== m_hi) begin bad++; $display("FAIL mfhi_after: got %h want %h", rd_data, m_hi); end
    op = 4'd0;
    #1;
    total++; if (rd_data !== 32'd0) begin bad++; $display("FAIL rd_none: got %h want 0", rd_data); end
    valid = 1'b0;
    run_op(4'd1, $urandom, $urandom, "b2b_second");
    run_op(4'd3, $urandom, $urandom_range(1, 100), "b2b_third");
  endtask

  task automatic test_random;
    logic [3:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      o = 4'($urandom_range(1, 8));
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      if ((o == 4'd3 || o == 4'd4) && $urandom_range(0, 5) == 0) b = 32'd0;
      case (o)
        4'd1, 4'd2, 4'd3, 4'd4: run_op(o, a, b, "rand_op");
        4'd5, 4'd6: begin
          valid = 1'b1; op = o;
          #1;
          total++;
          if (rd_data !== ((o == 4'd5) ? m_hi : m_lo)) begin
            bad++; $display("FAIL rand_mf%0d: got %h want %h", o, rd_data, (o == 4'd5) ? m_hi : m_lo);
          end
          valid = 1'b0; op = 4'd0;
          step;
        end
        default: do_mt(o, a);
      endcase
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_op;
    test_mult;
    test_div;
    test_div_zero_blocked;
    test_back_to_back;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
